// File: rtl/nn_sample_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : nn_sample_loader_if
// Purpose  : Bundles the feature-byte stream and the network-facing word
//            port of nn_sample_loader.
// Ports    : in_data/in_valid/in_ready -- byte stream (valid/ready)
//            nn_addr/nn_data           -- word read port for the network
//            nn_start/nn_done/busy     -- sample ownership handshake
//            sample_cnt                -- count of issued nn_start pulses
// Modports : master = feeder/network side, slave = loader side
// Revision : 1.0 - initial release
// ============================================================================
interface nn_sample_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] nn_addr;
  logic [31:0]       nn_data;
  logic              nn_start;
  logic              nn_done;
  logic              busy;
  logic [15:0]       sample_cnt;

  modport master (
    output in_data, in_valid, nn_addr, nn_done,
    input  in_ready, nn_data, nn_start, busy, sample_cnt
  );

  modport slave (
    input  in_data, in_valid, nn_addr, nn_done,
    output in_ready, nn_data, nn_start, busy, sample_cnt
  );
endinterface
`default_nettype wire

// File: rtl/nn_sample_loader.sv
`default_nettype none
// ============================================================================
// Module   : nn_sample_loader
// Purpose  : Packs an 8-bit feature stream, four bytes per 32-bit word, into
//            a sample buffer of N_WORDS words. When a sample is complete it
//            pulses nn_start and serves words by address (one-cycle read
//            latency) until the network returns nn_done.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous, active-low reset
//            bus  - nn_sample_loader_if.slave (stream in, word port out)
// Options  : LOADER_PINGPONG_EN - two buffer banks; loading of the next
//            sample overlaps the network run of the current one.
// Revision : 1.0 - initial release
// ============================================================================
module nn_sample_loader #(
  parameter int N_WORDS = 196,
  parameter int ADDR_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  nn_sample_loader_if.slave   bus
);

  localparam int WPTR_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
`ifdef LOADER_PINGPONG_EN
  localparam int BANKS  = 2;
`else
  localparam int BANKS  = 1;
`endif
  localparam int DEPTH   = BANKS * N_WORDS;
  localparam int MADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,   // network idle
    ST_FIRE = 2'd1,   // nn_start cycle
    ST_RUN  = 2'd2    // network owns the run bank
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          byte_ptr_q, byte_ptr_d;
  logic [WPTR_W-1:0]   word_ptr_q, word_ptr_d;
  logic [23:0]         asm_q, asm_d;          // bytes 0..2 of the word in progress
  logic                in_ready_q, in_ready_d;
  logic                nn_start_q, nn_start_d;
  logic                busy_q, busy_d;
  logic [15:0]         sample_cnt_q, sample_cnt_d;
  logic [31:0]         nn_data_q, nn_data_d;
`ifdef LOADER_PINGPONG_EN
  logic                load_bank_q, load_bank_d;
  logic                full_q, full_d;        // load bank complete, not yet handed over
  logic                full_now;
  logic                swap;
`endif

  logic [31:0]         mem_q [DEPTH];
  logic                wr_en;
  logic [MADDR_W-1:0]  wr_addr;
  logic [MADDR_W-1:0]  rd_addr;
  logic [31:0]         wr_data;
  logic                rd_in_range;
  logic                xfer;
  logic                last_byte;

  assign xfer        = bus.in_valid & in_ready_q;
  assign last_byte   = xfer && (byte_ptr_q == 2'd3) &&
                       (word_ptr_q == WPTR_W'(N_WORDS - 1));
  assign rd_in_range = (bus.nn_addr < ADDR_W'(N_WORDS));
  assign wr_data     = {bus.in_data, asm_q};

  // Bank 0 occupies words [0, N_WORDS), bank 1 the words above it. The
  // network always reads the bank opposite the one being loaded.
`ifdef LOADER_PINGPONG_EN
  assign wr_addr = load_bank_q ? (MADDR_W'(N_WORDS) + MADDR_W'(word_ptr_q))
                               : MADDR_W'(word_ptr_q);
  assign rd_addr = load_bank_q ? MADDR_W'(bus.nn_addr[WPTR_W-1:0])
                               : (MADDR_W'(N_WORDS) + MADDR_W'(bus.nn_addr[WPTR_W-1:0]));
`else
  assign wr_addr = MADDR_W'(word_ptr_q);
  assign rd_addr = MADDR_W'(bus.nn_addr[WPTR_W-1:0]);
`endif

  always_comb begin
    state_d      = state_q;
    byte_ptr_d   = byte_ptr_q;
    word_ptr_d   = word_ptr_q;
    asm_d        = asm_q;
    sample_cnt_d = sample_cnt_q;
    wr_en        = 1'b0;
`ifdef LOADER_PINGPONG_EN
    full_now     = full_q | last_byte;
    swap         = 1'b0;
`endif

    // Byte packing: the first three bytes are staged, the fourth completes
    // the word and triggers a single full-word buffer write.
    if (xfer) begin
      wr_en      = (byte_ptr_q == 2'd3);
      byte_ptr_d = byte_ptr_q + 2'd1;
      case (byte_ptr_q)
        2'd0:    asm_d[7:0]   = bus.in_data;
        2'd1:    asm_d[15:8]  = bus.in_data;
        2'd2:    asm_d[23:16] = bus.in_data;
        default: ;
      endcase
      if (byte_ptr_q == 2'd3) begin
        word_ptr_d = last_byte ? '0 : (word_ptr_q + WPTR_W'(1));
      end
    end

`ifdef LOADER_PINGPONG_EN
    case (state_q)
      ST_LOAD: begin
        if (full_now) begin
          state_d = ST_FIRE;
          swap    = 1'b1;
        end
      end
      ST_FIRE: state_d = ST_RUN;
      ST_RUN: begin
        // A sample completed on the same edge as nn_done is handed over
        // immediately, keeping busy high across the boundary.
        if (bus.nn_done) begin
          if (full_now) begin
            state_d = ST_FIRE;
            swap    = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
    full_d      = full_now & ~swap;
    load_bank_d = load_bank_q ^ swap;
`else
    case (state_q)
      ST_LOAD: if (last_byte)   state_d = ST_FIRE;
      ST_FIRE:                  state_d = ST_RUN;
      ST_RUN:  if (bus.nn_done) state_d = ST_LOAD;
      default:                  state_d = ST_LOAD;
    endcase
`endif

    // FIRE always exits after one cycle, so landing in it means entering it.
    if (state_d == ST_FIRE) begin
      sample_cnt_d = sample_cnt_q + 16'd1;
    end

    // Outputs are registered from the next state so that they are all zero
    // while reset is held and line up with the state they describe.
    nn_start_d = (state_d == ST_FIRE);
    busy_d     = (state_d != ST_LOAD);
`ifdef LOADER_PINGPONG_EN
    in_ready_d = ~full_d;
`else
    in_ready_d = (state_d == ST_LOAD);
`endif
    nn_data_d  = rd_in_range ? mem_q[rd_addr] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_LOAD;
      byte_ptr_q   <= '0;
      word_ptr_q   <= '0;
      asm_q        <= '0;
      in_ready_q   <= 1'b0;
      nn_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      sample_cnt_q <= '0;
      nn_data_q    <= '0;
`ifdef LOADER_PINGPONG_EN
      load_bank_q  <= 1'b0;
      full_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      byte_ptr_q   <= byte_ptr_d;
      word_ptr_q   <= word_ptr_d;
      asm_q        <= asm_d;
      in_ready_q   <= in_ready_d;
      nn_start_q   <= nn_start_d;
      busy_q       <= busy_d;
      sample_cnt_q <= sample_cnt_d;
      nn_data_q    <= nn_data_d;
`ifdef LOADER_PINGPONG_EN
      load_bank_q  <= load_bank_d;
      full_q       <= full_d;
`endif
    end
  end

  // Buffer storage carries no reset; its contents are meaningless until a
  // sample has been loaded.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.nn_start   = nn_start_q;
  assign bus.busy       = busy_q;
  assign bus.sample_cnt = sample_cnt_q;
  assign bus.nn_data    = nn_data_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_sample_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_sample_loader
// Purpose  : Directed, self-checking bench for nn_sample_loader in its
//            single-bank build: reset, packing, backpressure, reset during
//            load, sample counter and busy window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_sample_loader;

  localparam int NW = 196;
  localparam int AW = 16;
  localparam int NB = NW * 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   start_seen = 0;
  int   base_starts;
  int   busy_low;

  nn_sample_loader_if #(.ADDR_W(AW)) bus ();

  nn_sample_loader #(.N_WORDS(NW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.nn_start === 1'b1) start_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one byte and waits for it to be taken.
  task automatic push(input logic [7:0] b);
    logic acc;
    int   guard;
    guard = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    do begin
      acc = bus.in_ready;
      tick();
      guard++;
    end while (!acc && guard < 2000);
    if (!acc) check("push_timeout", 32'(acc), 32'd1);
  endtask

  task automatic stream(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) push(base + 8'(i));
    bus.in_valid = 1'b0;
  endtask

  task automatic read_word(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    bus.nn_addr = a;
    tick();
    check(tag, bus.nn_data, exp);
  endtask

  initial begin
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    bus.nn_addr  = '0;
    bus.nn_done  = 1'b0;

    // Reset held three cycles with valid asserted
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_in_ready", 32'(bus.in_ready),   32'd0);
      check("rst_nn_start", 32'(bus.nn_start),   32'd0);
      check("rst_busy",     32'(bus.busy),       32'd0);
      check("rst_cnt",      32'(bus.sample_cnt), 32'd0);
      check("rst_nn_data",  bus.nn_data,         32'd0);
    end
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    check("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // nn_done while idle is ignored
    bus.nn_done = 1'b1;
    tick();
    bus.nn_done = 1'b0;
    check("idle_done_busy",  32'(bus.busy),     32'd0);
    check("idle_done_ready", 32'(bus.in_ready), 32'd1);

    // Sample 1: bytes 0x00,0x01,... then hold a pending byte
    stream(8'h00, NB);
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    check("s1_start",      32'(bus.nn_start),   32'd1);
    check("s1_cnt",        32'(bus.sample_cnt), 32'd1);
    check("s1_busy_fire",  32'(bus.busy),       32'd1);
    check("s1_ready_fire", 32'(bus.in_ready),   32'd0);
    read_word("s1_word0", 16'd0, 32'h03020100);
    check("s1_start_once", 32'(bus.nn_start), 32'd0);
    check("s1_ready_run0", 32'(bus.in_ready), 32'd0);
    read_word("s1_word1",   16'd1,        32'h07060504);
    read_word("s1_wordlast", 16'(NW - 1), 32'h0F0E0D0C);
    read_word("s1_oob",     16'(NW),      32'h0);
    read_word("s1_oob_max", 16'hFFFF,     32'h0);
    check("s1_ready_run1", 32'(bus.in_ready), 32'd0);
    check("s1_busy_run",   32'(bus.busy),     32'd1);
    check("s1_starts",     32'(start_seen),   32'd1);

    // Release the sample; the held byte is taken only after nn_done
    bus.nn_done = 1'b1;
    check("bp_ready_at_done", 32'(bus.in_ready), 32'd0);
    tick();
    bus.nn_done = 1'b0;
    check("bp_ready_after_done", 32'(bus.in_ready), 32'd1);
    check("bp_busy_after_done",  32'(bus.busy),     32'd0);
    push(8'hAA);
    stream(8'hAB, NB - 1);
    check("s2_start", 32'(bus.nn_start),   32'd1);
    check("s2_cnt",   32'(bus.sample_cnt), 32'd2);
    read_word("s2_word0", 16'd0, 32'hADACABAA);
    read_word("s2_word1", 16'd1, 32'hB1B0AFAE);
    bus.nn_done = 1'b1;
    tick();
    bus.nn_done = 1'b0;
    check("s2_busy_clear", 32'(bus.busy), 32'd0);

    // Reset after 10 bytes, then a fresh sample
    stream(8'hE0, 10);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_cnt",   32'(bus.sample_cnt), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready),   32'd1);
    base_starts = start_seen;
    stream(8'h50, NB);
    check("fresh_start", 32'(bus.nn_start),   32'd1);
    check("fresh_cnt",   32'(bus.sample_cnt), 32'd1);
    read_word("fresh_word0", 16'd0, 32'h53525150);
    read_word("fresh_word2", 16'd2, 32'h5B5A5958);
    tick();
    check("fresh_one_start", 32'(start_seen - base_starts), 32'd1);
    bus.nn_done = 1'b1;
    tick();
    bus.nn_done = 1'b0;

    // Two more samples, nn_done 20 cycles after each start
    for (int s = 0; s < 2; s++) begin
      stream(8'h10 + 8'(s), NB);
      check("cnt_start", 32'(bus.nn_start), 32'd1);
      busy_low = 0;
      for (int c = 0; c < 20; c++) begin
        if (bus.busy !== 1'b1) busy_low++;
        tick();
      end
      if (bus.busy !== 1'b1) busy_low++;
      check("cnt_busy_window", 32'(busy_low), 32'd0);
      bus.nn_done = 1'b1;
      tick();
      bus.nn_done = 1'b0;
      check("cnt_busy_clear",  32'(bus.busy),     32'd0);
      check("cnt_ready_again", 32'(bus.in_ready), 32'd1);
    end
    check("cnt_final", 32'(bus.sample_cnt), 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
